matrix_mac_seq: RTL

Parametrised, resource-shared successor to the fixed 3x3 8-bit matrix block. Computes Out = A×B, or Out = Out + A×B in accumulate mode, for N×N matrices of W-bit elements using one multiply-accumulate unit. Each operation takes N³ cycles and ends with a Load/Busy/Done handshake. Selectable signedness and saturation, plus a sticky overflow flag, let the block sit behind the lab datapath as a reusable matrix engine.

---
 rtl/matrix_mac_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/matrix_mac_seq.sv
// matrix_mac_seq
// Resource-shared N x N matrix multiply(-accumulate) engine. One MAC unit walks
// (i, j, k) row-major with k innermost, so one operation takes N^3 cycles.
// Out = A x B, or Out = Out + A x B when Accum is captured high. Each element
// result is range-checked against OW bits, then clamped (SAT=1) or wrapped (SAT=0).
//
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  synchronous active-low reset
//   i_load     start request, accepted only while idle
//   i_accum    1 = add the product into the existing Out
//   i_a, i_b   flattened matrices, element (i,j) at [(i*N+j)*W +: W]
//   o_out      result matrix, element (i,j) at [(i*N+j)*OW +: OW]
//   o_busy     operation in progress
//   o_done     one-cycle completion pulse
//   o_ovf      sticky: some element of the last operation was out of range
module matrix_mac_seq #(
   parameter int unsigned N      = 3,
   parameter int unsigned W      = 8,
   parameter int unsigned OW     = 8,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned SAT    = 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_load,
   input  logic              i_accum,
   input  logic [N*N*W-1:0]  i_a,
   input  logic [N*N*W-1:0]  i_b,
   output logic [N*N*OW-1:0] o_out,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_ovf
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned AW = 2 * W + $clog2(N) + 1;
   localparam int unsigned PW = 2 * W + 2;
   // Element result width: wide enough for acc plus an extended Out term.
   localparam int unsigned RW = AW + OW + 2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic signed [RW-1:0] ONE = RW'(1);
   localparam logic signed [RW-1:0] HI  = (SIGNED != 0) ? (ONE <<< (OW - 1)) - ONE
                                                        : (ONE <<< OW) - ONE;
   localparam logic signed [RW-1:0] LO  = (SIGNED != 0) ? -(ONE <<< (OW - 1)) : '0;

   logic [0:0]              r_state;
   logic [N*N*W-1:0]        r_a;
   logic [N*N*W-1:0]        r_b;
   logic                    r_accum;
   logic [IW-1:0]           r_i;
   logic [IW-1:0]           r_j;
   logic [IW-1:0]           r_k;
   logic signed [AW-1:0]    r_acc;
   logic [N*N*OW-1:0]       r_out;
   logic                    r_done;
   logic                    r_ovf;

   logic [W-1:0]            w_a_el;
   logic [W-1:0]            w_b_el;
   logic [OW-1:0]           w_out_el;
   logic signed [PW-1:0]    w_a_ext;
   logic signed [PW-1:0]    w_b_ext;
   logic signed [PW-1:0]    w_prod;
   logic signed [AW-1:0]    w_acc_sum;
   logic signed [RW-1:0]    w_out_ext;
   logic signed [RW-1:0]    w_r;
   logic                    w_oor;
   logic [OW-1:0]           w_wr_el;
   logic                    w_last_k;
   logic                    w_last_j;
   logic                    w_last_i;

   always_comb begin
      w_a_el   = r_a[(32'(r_i) * N + 32'(r_k)) * W +: W];
      w_b_el   = r_b[(32'(r_k) * N + 32'(r_j)) * W +: W];
      w_out_el = r_out[(32'(r_i) * N + 32'(r_j)) * OW +: OW];

      // Both signedness modes share one signed multiplier; unsigned operands
      // are zero-extended so they stay non-negative.
      if (SIGNED != 0) begin
         w_a_ext   = PW'($signed(w_a_el));
         w_b_ext   = PW'($signed(w_b_el));
         w_out_ext = RW'($signed(w_out_el));
      end else begin
         w_a_ext   = {{(PW - W){1'b0}}, w_a_el};
         w_b_ext   = {{(PW - W){1'b0}}, w_b_el};
         w_out_ext = {{(RW - OW){1'b0}}, w_out_el};
      end

      w_prod    = w_a_ext * w_b_ext;
      w_acc_sum = r_acc + AW'(w_prod);
      w_r       = RW'(w_acc_sum) + (r_accum ? w_out_ext : '0);

      w_oor = (w_r > HI) || (w_r < LO);
      if (SAT != 0 && w_r > HI) begin
         w_wr_el = HI[OW-1:0];
      end else if (SAT != 0 && w_r < LO) begin
         w_wr_el = LO[OW-1:0];
      end else begin
         w_wr_el = w_r[OW-1:0];
      end

      w_last_k = (r_k == IW'(N - 1));
      w_last_j = (r_j == IW'(N - 1));
      w_last_i = (r_i == IW'(N - 1));
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_accum <= 1'b0;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_acc   <= '0;
         r_out   <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_load) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_accum <= i_accum;
                  r_ovf   <= 1'b0;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_k     <= '0;
                  r_acc   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_last_k) begin
                  r_out[(32'(r_i) * N + 32'(r_j)) * OW +: OW] <= w_wr_el;
                  if (w_oor) begin
                     r_ovf <= 1'b1;
                  end
                  r_acc <= '0;
                  r_k   <= '0;
                  if (w_last_j) begin
                     r_j <= '0;
                     if (w_last_i) begin
                        r_i     <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                     end else begin
                        r_i <= r_i + 1'b1;
                     end
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end else begin
                  r_acc <= w_acc_sum;
                  r_k   <= r_k + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_out  = r_out;
   assign o_busy = (r_state == ST_RUN);
   assign o_done = r_done;
   assign o_ovf  = r_ovf;

endmodule
